regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; next generation of the single-port regfile.
- Provides 1 write port and NUM_RD independent read ports, with registered reads (1-cycle latency) and optional write-to-read bypass.
- Keeps a per-entry "written" flag and includes a hardware clear sweeper that zeroes every entry after reset or on request.
- Sits beside the datapath as the general-purpose operand store.

Parameters:
- DATA_WIDTH, 16, bits per entry
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries
- NUM_RD, 2, number of read ports (>=1)
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns wr_data; 0 = returns the old contents
- ZERO_REG, 0, 1 = entry 0 is hardwired zero, writes to it are discarded

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  packed registered read data
- rd_vld  out  NUM_RD  per-port: rd_data updated this cycle from an entry written since the last clear
- rd_ack  out  NUM_RD  per-port: read accepted last cycle
- clr_req  in  1  request full clear (single-cycle pulse)
- busy  out  1  clear sweep in progress; accesses ignored

Behaviour:
- Reset (rst=1 at an edge):
  - rd_data=0, rd_vld=0, rd_ack=0, busy=1.
  - FSM goes to SWEEP with sweep pointer 0.
  - Written flags are all cleared.
  - Storage contents are not reset directly; the sweep zeroes them.
- FSM states:
  - SWEEP: each cycle writes 0 to entry[ptr] and increments ptr. When ptr==DEPTH-1, the next state is IDLE. busy=1 throughout SWEEP.
  - Sweep duration: exactly DEPTH cycles after rst deasserts; busy falls on the edge that completes entry DEPTH-1.
  - IDLE: busy=0; normal access. clr_req=1 -> SWEEP with ptr=0 and all written flags cleared on the same edge.
  - In SWEEP, clr_req is ignored (the sweep continues).
  - rst mid-sweep restarts the sweep at ptr 0.
- Writes (IDLE only):
  - wr_en=1 -> entry[wr_addr] <= wr_data and written[wr_addr] <= 1 at the edge.
  - ZERO_REG=1 and wr_addr==0 -> the write is discarded and the flag stays 0.
- Reads (IDLE only):
  - rd_en[k] sampled at edge N -> rd_data[k], rd_vld[k] and rd_ack[k]=1 valid after edge N (1-cycle latency).
  - When rd_en[k]=0, rd_data[k] holds its previous value and rd_ack[k]=0.
  - rd_vld[k] = written flag of the addressed entry (including a same-cycle bypassed write).
- Same-cycle write and read of the same address:
  - BYPASS=1 -> returns wr_data with rd_vld=1.
  - BYPASS=0 -> returns the old contents and the old flag.
- ZERO_REG=1 read of address 0 -> rd_data=0, rd_vld=1.
- Port independence: all read ports may address the same or different entries in the same cycle, with no conflicts.
- During SWEEP: wr_en and rd_en are ignored, rd_ack=0, rd_vld=0, rd_data holds its value.
- clr_req and wr_en in the same IDLE cycle: the clear wins; the write is dropped.

Decomposition:
- Shared package (regfile_pkg) holds:
  - the FSM state enum (SWEEP, IDLE);
  - default-width constants matching the codebase DATA_WIDTH / DATA_ADDR_WIDTH defines;
  - the packed-port slice helper function.
- One natural sub-module, regfile_rd_port: the read mux, bypass compare and output register for a single port, instantiated NUM_RD times via generate.

Test Plan:
- Reset then idle: rst high 2 cycles then low -> busy=1 for exactly 16 cycles (DEPTH=16), then 0; reading all 16 addresses gives rd_data=0, rd_vld=0.
- Write/readback: write 0xBEEF to addr 5; next cycle read addr 5 on port 0 and addr 6 on port 1 -> one cycle later port0 0xBEEF/vld=1, port1 0x0000/vld=0, both ack=1.
- Bypass: wr_en addr 3 = 0x1234 with rd_en port1 addr 3 in the same cycle; BYPASS=1 -> 0x1234/vld=1; BYPASS=0 -> 0x0000/vld=0.
- Clear: fill all entries with 0xA5A5, pulse clr_req together with wr_en to addr 2 = 0x7777 -> busy=1 for 16 cycles, reads ignored (ack=0) during the sweep; afterwards all reads 0, vld=0, including addr 2.
- Reset mid-sweep: assert rst at sweep cycle 7 -> sweep restarts; busy stays high for 16 cycles after rst deasserts.
- ZERO_REG=1: write 0xFFFF to addr 0 -> read returns 0x0000, vld=1; NUM_RD=4, all four ports reading addr 9 simultaneously -> identical data.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;

  // LSB of port k inside a packed per-port bus of the given field width
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: entry select, optional write bypass, zero-reg override.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_en,
  input  logic [ADDR_WIDTH-1:0]                 i_addr,
  input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] i_mem,
  input  logic [(2**ADDR_WIDTH)-1:0]            i_written,
  input  logic                                  i_wr_do,
  input  logic [ADDR_WIDTH-1:0]                 i_wr_addr,
  input  logic [DATA_WIDTH-1:0]                 i_wr_data,
  output logic [DATA_WIDTH-1:0]                 o_data,
  output logic                                  o_vld,
  output logic                                  o_ack
);

  logic                  w_zero;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_vld;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_vld;
  logic                  r_ack;

  assign w_zero = (ZERO_REG != 0) && (i_addr == '0);
  assign w_hit  = (BYPASS != 0) && i_wr_do && (i_wr_addr == i_addr);

  always_comb begin
    w_data = i_mem[int'(i_addr)*DATA_WIDTH +: DATA_WIDTH];
    w_vld  = i_written[i_addr];
    if (w_zero) begin
      w_data = '0;
      w_vld  = 1'b1;
    end else if (w_hit) begin
      w_data = i_wr_data;
      w_vld  = 1'b1;
    end
  end

  // Data holds when idle; vld/ack only describe a read accepted at this edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_ack  <= 1'b0;
    end else if (i_en) begin
      r_data <= w_data;
      r_vld  <= w_vld;
      r_ack  <= 1'b1;
    end else begin
      r_vld  <= 1'b0;
      r_ack  <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;
  assign o_ack  = r_ack;

endmodule

// File: rtl/regfile_mp.sv
// Register file, 1 write port, NUM_RD registered read ports, hardware clear sweep.
// state    | meaning
// ST_SWEEP | zeroing entry[r_ptr] each cycle, accesses ignored, busy=1
// ST_IDLE  | normal reads/writes, clr_req restarts the sweep
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr_en,
  input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  input  logic [NUM_RD-1:0]            i_rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
  output logic [NUM_RD-1:0]            o_rd_vld,
  output logic [NUM_RD-1:0]            o_rd_ack,
  input  logic                         i_clr_req,
  output logic                         o_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);

  state_e                        r_state;
  logic [ADDR_WIDTH-1:0]         r_ptr;
  logic                          r_busy;
  logic [DEPTH-1:0]              r_written;
  logic [DATA_WIDTH-1:0]         r_mem [DEPTH];
  logic [DEPTH*DATA_WIDTH-1:0]   w_mem_flat;
  logic                          w_idle;
  logic                          w_wr_do;
  logic                          w_sweep_wr;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_sweep_wr = (r_state == ST_SWEEP) && !i_rst;
  // A clear request in the same cycle drops the write
  assign w_wr_do    = w_idle && i_wr_en && !i_clr_req &&
                      !((ZERO_REG != 0) && (i_wr_addr == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_SWEEP;
      r_ptr     <= '0;
      r_busy    <= 1'b1;
      r_written <= '0;
    end else begin
      case (r_state)
        ST_SWEEP: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (i_clr_req) begin
            r_state   <= ST_SWEEP;
            r_ptr     <= '0;
            r_busy    <= 1'b1;
            r_written <= '0;
          end else if (w_wr_do) begin
            r_written[i_wr_addr] <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_SWEEP;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_sweep_wr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_do) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_flat
    assign w_mem_flat[e*DATA_WIDTH +: DATA_WIDTH] = r_mem[e];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_rd_en[k] & w_idle),
      .i_addr    (i_rd_addr[port_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH]),
      .i_mem     (w_mem_flat),
      .i_written (r_written),
      .i_wr_do   (w_wr_do),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .o_data    (o_rd_data[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .o_vld     (o_rd_vld[k]),
      .o_ack     (o_rd_ack[k])
    );
  end

  assign o_busy = r_busy;

endmodule
